// File: rtl/cpu_mailbox.sv
// CPU-visible mailbox: a 16-byte register window in front of a host-to-device TX FIFO
// and a device-to-host RX FIFO, with sticky error flags and a registered interrupt.
module cpu_mailbox #(
  parameter logic [15:0] BASE_ADDR = 16'h5000,
  parameter int          DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPURead,
  input  logic        CPUWrite,
  input  logic [15:0] CPUAddress,
  input  logic [31:0] CPUWriteData,
  output logic [31:0] CPUReadData,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        irq
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

  localparam logic [1:0] SEL_TXDATA = 2'd0;
  localparam logic [1:0] SEL_RXDATA = 2'd1;
  localparam logic [1:0] SEL_STATUS = 2'd2;
  localparam logic [1:0] SEL_CTRL   = 2'd3;

  // Address decode; a simultaneous read+write strobe is a write only.
  logic [15:0] offset;
  logic        in_win;
  logic [1:0]  reg_sel;
  logic        wr_en;
  logic        rd_any;
  logic        rd_en;
  logic        unused_addr_lsbs;

  assign offset           = CPUAddress - BASE_ADDR;
  assign in_win           = (offset[15:4] == 12'd0);
  assign reg_sel          = offset[3:2];
  assign wr_en            = CPUWrite & in_win;
  assign rd_any           = CPURead & ~CPUWrite;
  assign rd_en            = rd_any & in_win;
  assign unused_addr_lsbs = ^offset[1:0];

  // TX FIFO
  logic [31:0]   tx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr;
  logic [AW-1:0] tx_rd_ptr;
  logic [3:0]    tx_count;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_push_req;
  logic          tx_push;
  logic          tx_pop;

  // RX FIFO
  logic [31:0]   rx_mem [DEPTH];
  logic [AW-1:0] rx_wr_ptr;
  logic [AW-1:0] rx_rd_ptr;
  logic [3:0]    rx_count;
  logic          rx_full;
  logic          rx_empty;
  logic          rx_pop_req;
  logic          rx_pop;
  logic          rx_push;

  logic [1:0]  ctrl;
  logic        tx_overflow;
  logic        rx_underflow;
  logic        ovf_clr;
  logic        udf_clr;
  logic [31:0] status;
  logic [31:0] rd_mux;

  // Both device ports use valid/ready: a word transfers on the rising edge where
  // valid and ready are both high; valid never depends on ready.
  assign tx_full     = (tx_count == DEPTH_CNT);
  assign tx_empty    = (tx_count == 4'd0);
  assign tx_push_req = wr_en & (reg_sel == SEL_TXDATA);
  assign tx_push     = tx_push_req & ~tx_full;
  assign tx_pop      = out_valid & out_ready;
  assign out_valid   = ~tx_empty;
  assign out_data    = tx_mem[tx_rd_ptr];

  assign rx_full    = (rx_count == DEPTH_CNT);
  assign rx_empty   = (rx_count == 4'd0);
  assign rx_pop_req = rd_en & (reg_sel == SEL_RXDATA);
  assign rx_pop     = rx_pop_req & ~rx_empty;
  assign in_ready   = ~rx_full;
  assign rx_push    = in_valid & in_ready;

  assign ovf_clr = wr_en & (reg_sel == SEL_STATUS) & CPUWriteData[2];
  assign udf_clr = wr_en & (reg_sel == SEL_STATUS) & CPUWriteData[3];

  assign status = {12'd0, rx_count, 4'd0, tx_count, 4'd0,
                   rx_underflow, tx_overflow, tx_full, ~rx_empty};

  always_ff @(posedge clk) begin
    if (!reset && tx_push) tx_mem[tx_wr_ptr] <= CPUWriteData;
    if (!reset && rx_push) rx_mem[rx_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 4'd1;
        2'b01:   tx_count <= tx_count - 4'd1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 4'd1;
        2'b01:   rx_count <= rx_count - 4'd1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (reg_sel)
      SEL_TXDATA: rd_mux = 32'd0;
      SEL_RXDATA: rd_mux = rx_empty ? 32'd0 : rx_mem[rx_rd_ptr];
      SEL_STATUS: rd_mux = status;
      SEL_CTRL:   rd_mux = {30'd0, ctrl};
      default:    rd_mux = 32'd0;
    endcase
  end

  // Hardware set wins over a same-cycle W1C clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl         <= 2'd0;
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
      CPUReadData  <= 32'd0;
      irq          <= 1'b0;
    end else begin
      if (wr_en && reg_sel == SEL_CTRL) ctrl <= CPUWriteData[1:0];
      tx_overflow  <= (tx_push_req & tx_full) | (tx_overflow & ~ovf_clr);
      rx_underflow <= (rx_pop_req & rx_empty) | (rx_underflow & ~udf_clr);
      if (rd_any) CPUReadData <= in_win ? rd_mux : 32'd0;
      irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty) | tx_overflow | rx_underflow;
    end
  end

endmodule
